// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: register index width, the x0 index and ALU op codes.
package riscv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

endpackage

// File: rtl/operand_forward.sv
// Forwarding mux for one source operand: EX/MEM result beats MEM/WB writeback,
// x0 is never forwarded, and a load in EX/MEM has no usable value yet.
module operand_forward
  import riscv_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic [REG_ADDR_W-1:0] idx,
  input  logic [WORDSIZE-1:0]   value,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [WORDSIZE-1:0]   ex_value,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [WORDSIZE-1:0]   wb_value,
  output logic [WORDSIZE-1:0]   result
);

  logic hit_ex;
  logic hit_wb;

  assign hit_ex = ex_valid & ~ex_is_load & (ex_rd == idx) & (idx != REG_X0);
  assign hit_wb = wb_valid & (wb_rd == idx) & (idx != REG_X0);

  // Priority select: the younger EX/MEM result shadows the older writeback.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    result = value;
    if (hit_ex) begin
      result = ex_value;
    end else if (hit_wb) begin
      result = wb_value;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX stage ahead of the ALU: holds one decoded instruction, forwards RAW
// results into it, stalls on load-use, and handshakes valid/ready both ways.
module alu_operand_stage
  import riscv_pkg::*;
#(
  parameter int WORDSIZE   = 64,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [WORDSIZE-1:0]   in_rs1_value,
  input  logic [WORDSIZE-1:0]   in_rs2_value,
  input  logic [WORDSIZE-1:0]   in_imm,
  input  logic [WORDSIZE-1:0]   in_pc,
  input  logic                  in_a_sel_pc,
  input  logic                  in_b_sel_imm,
  input  logic [2:0]            in_operation,
  input  logic                  fwd_ex_valid,
  input  logic [REG_ADDR_W-1:0] fwd_ex_rd,
  input  logic [WORDSIZE-1:0]   fwd_ex_value,
  input  logic                  fwd_ex_is_load,
  input  logic                  fwd_wb_valid,
  input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
  input  logic [WORDSIZE-1:0]   fwd_wb_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORDSIZE-1:0]   input_a,
  output logic [WORDSIZE-1:0]   input_b,
  output logic [2:0]            operation,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [WORDSIZE-1:0]   out_rs2_value
);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [WORDSIZE-1:0]   rs1_value;
    logic [WORDSIZE-1:0]   rs2_value;
    logic [WORDSIZE-1:0]   imm;
    logic [WORDSIZE-1:0]   pc;
    logic                  a_sel_pc;
    logic                  b_sel_imm;
    alu_op_e               op;
  } stage_t;

  state_e state_q;
  state_e state_d;
  stage_t stage_q;

  logic                held_valid;
  logic                hazard;
  logic                capture;
  logic                consume;
  logic                refresh;
  logic [WORDSIZE-1:0] cap_rs1_fwd;
  logic [WORDSIZE-1:0] cap_rs2_fwd;
  logic [WORDSIZE-1:0] st_rs1_fwd;
  logic [WORDSIZE-1:0] st_rs2_fwd;

  // Capture path: closes the gap where the register file has not yet seen a write.
  operand_forward #(.WORDSIZE(WORDSIZE)) u_cap_rs1 (
    .idx(in_rs1), .value(in_rs1_value),
    .ex_valid(fwd_ex_valid), .ex_is_load(fwd_ex_is_load), .ex_rd(fwd_ex_rd), .ex_value(fwd_ex_value),
    .wb_valid(fwd_wb_valid), .wb_rd(fwd_wb_rd), .wb_value(fwd_wb_value),
    .result(cap_rs1_fwd)
  );

  operand_forward #(.WORDSIZE(WORDSIZE)) u_cap_rs2 (
    .idx(in_rs2), .value(in_rs2_value),
    .ex_valid(fwd_ex_valid), .ex_is_load(fwd_ex_is_load), .ex_rd(fwd_ex_rd), .ex_value(fwd_ex_value),
    .wb_valid(fwd_wb_valid), .wb_rd(fwd_wb_rd), .wb_value(fwd_wb_value),
    .result(cap_rs2_fwd)
  );

  // Stored path: drives the ALU operands and refreshes a stalled instruction.
  operand_forward #(.WORDSIZE(WORDSIZE)) u_st_rs1 (
    .idx(stage_q.rs1), .value(stage_q.rs1_value),
    .ex_valid(fwd_ex_valid), .ex_is_load(fwd_ex_is_load), .ex_rd(fwd_ex_rd), .ex_value(fwd_ex_value),
    .wb_valid(fwd_wb_valid), .wb_rd(fwd_wb_rd), .wb_value(fwd_wb_value),
    .result(st_rs1_fwd)
  );

  operand_forward #(.WORDSIZE(WORDSIZE)) u_st_rs2 (
    .idx(stage_q.rs2), .value(stage_q.rs2_value),
    .ex_valid(fwd_ex_valid), .ex_is_load(fwd_ex_is_load), .ex_rd(fwd_ex_rd), .ex_value(fwd_ex_value),
    .wb_valid(fwd_wb_valid), .wb_rd(fwd_wb_rd), .wb_value(fwd_wb_value),
    .result(st_rs2_fwd)
  );

  assign held_valid = (state_q == HELD);

  // rs2 counts even when imm is selected, because it still supplies store data.
  assign hazard = held_valid & fwd_ex_valid & fwd_ex_is_load & (fwd_ex_rd != REG_X0) &
                  (((fwd_ex_rd == stage_q.rs1) & ~stage_q.a_sel_pc) | (fwd_ex_rd == stage_q.rs2));

  assign out_valid = held_valid & ~hazard & ~flush;
  assign consume   = out_valid & out_ready;
  assign in_ready  = ~held_valid | consume;
  assign capture   = in_valid & in_ready & ~flush;
  assign refresh   = held_valid & ~consume;

  assign input_a       = stage_q.a_sel_pc  ? stage_q.pc  : st_rs1_fwd;
  assign input_b       = stage_q.b_sel_imm ? stage_q.imm : st_rs2_fwd;
  assign out_rs2_value = st_rs2_fwd;
  assign operation     = stage_q.op;
  assign out_rd        = stage_q.rd;

  // Valid-FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Valid-FSM next state: a capture refills the slot, flush or consume empties it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (capture) state_d = HELD;
      HELD: begin
        if (capture) begin
          state_d = HELD;
        end else if (flush | consume) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Stage registers: load on capture, otherwise keep re-forwarding a waiting operand.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the payload is reset too (not just the valid bit) so the ALU inputs read zero out of reset.
      stage_q <= '0;
    end else if (capture) begin
      stage_q <= '{rs1:       in_rs1,
                   rs2:       in_rs2,
                   rd:        in_rd,
                   rs1_value: cap_rs1_fwd,
                   rs2_value: cap_rs2_fwd,
                   imm:       in_imm,
                   pc:        in_pc,
                   a_sel_pc:  in_a_sel_pc,
                   b_sel_imm: in_b_sel_imm,
                   op:        alu_op_e'(in_operation)};
    end else if (refresh) begin
      stage_q.rs1_value <= st_rs1_fwd;
      stage_q.rs2_value <= st_rs2_fwd;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_alu_operand_stage;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready;
  logic [4:0]    in_rs1, in_rs2, in_rd;
  logic [W-1:0]  in_rs1_value, in_rs2_value, in_imm, in_pc;
  logic          in_a_sel_pc, in_b_sel_imm;
  logic [2:0]    in_operation;
  logic          fwd_ex_valid, fwd_ex_is_load, fwd_wb_valid;
  logic [4:0]    fwd_ex_rd, fwd_wb_rd;
  logic [W-1:0]  fwd_ex_value, fwd_wb_value;
  logic          out_valid, out_ready;
  logic [W-1:0]  input_a, input_b, out_rs2_value;
  logic [2:0]    operation;
  logic [4:0]    out_rd;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [4:0]   rs1, rs2, rd;
    logic [W-1:0] v1, v2, imm, pc;
    logic         asel, bsel;
    logic [2:0]   op;
  } instr_t;

  instr_t held_q[$];

  always #5 clk = ~clk;

  alu_operand_stage #(.WORDSIZE(W), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_value(in_rs1_value), .in_rs2_value(in_rs2_value),
    .in_imm(in_imm), .in_pc(in_pc),
    .in_a_sel_pc(in_a_sel_pc), .in_b_sel_imm(in_b_sel_imm), .in_operation(in_operation),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_value(fwd_ex_value),
    .fwd_ex_is_load(fwd_ex_is_load),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_value(fwd_wb_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .input_a(input_a), .input_b(input_b), .operation(operation),
    .out_rd(out_rd), .out_rs2_value(out_rs2_value)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Value a register index should read given the results in flight right now.
  function automatic logic [W-1:0] fwd(input logic [4:0] idx, input logic [W-1:0] val);
    if (idx == 5'd0) return val;
    if (fwd_ex_valid && !fwd_ex_is_load && fwd_ex_rd == idx) return fwd_ex_value;
    if (fwd_wb_valid && fwd_wb_rd == idx) return fwd_wb_value;
    return val;
  endfunction

  function automatic bit m_hazard();
    if (held_q.size() == 0) return 1'b0;
    return fwd_ex_valid && fwd_ex_is_load && fwd_ex_rd != 5'd0 &&
           ((fwd_ex_rd == held_q[0].rs1 && !held_q[0].asel) || fwd_ex_rd == held_q[0].rs2);
  endfunction

  function automatic bit m_out_valid();
    return held_q.size() != 0 && !m_hazard() && !flush;
  endfunction

  function automatic bit m_in_ready();
    return held_q.size() == 0 || (m_out_valid() && out_ready);
  endfunction

  // Compare every output against the model at mid-cycle.
  task automatic mid();
    logic [W-1:0] ea, eb;
    #4;
    check("out_valid", W'(out_valid), W'(m_out_valid()));
    check("in_ready",  W'(in_ready),  W'(m_in_ready()));
    if (m_out_valid()) begin
      ea = held_q[0].asel ? held_q[0].pc  : fwd(held_q[0].rs1, held_q[0].v1);
      eb = held_q[0].bsel ? held_q[0].imm : fwd(held_q[0].rs2, held_q[0].v2);
      check("input_a",       input_a,        ea);
      check("input_b",       input_b,        eb);
      check("out_rs2_value", out_rs2_value,  fwd(held_q[0].rs2, held_q[0].v2));
      check("operation",     W'(operation),  W'(held_q[0].op));
      check("out_rd",        W'(out_rd),     W'(held_q[0].rd));
    end
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic edge_step();
    bit ov, ir;
    instr_t n;
    @(posedge clk);
    ov = m_out_valid();
    ir = m_in_ready();
    if (reset || flush) begin
      held_q.delete();
    end else begin
      if (ov && out_ready) begin
        void'(held_q.pop_front());
      end else if (held_q.size() != 0) begin
        held_q[0].v1 = fwd(held_q[0].rs1, held_q[0].v1);
        held_q[0].v2 = fwd(held_q[0].rs2, held_q[0].v2);
      end
      if (in_valid && ir) begin
        n.rs1 = in_rs1; n.rs2 = in_rs2; n.rd = in_rd;
        n.v1 = fwd(in_rs1, in_rs1_value); n.v2 = fwd(in_rs2, in_rs2_value);
        n.imm = in_imm; n.pc = in_pc;
        n.asel = in_a_sel_pc; n.bsel = in_b_sel_imm; n.op = in_operation;
        held_q.push_back(n);
      end
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; flush = 0; in_valid = 0; out_ready = 1;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_rs1_value = 0; in_rs2_value = 0; in_imm = 0; in_pc = 0;
    in_a_sel_pc = 0; in_b_sel_imm = 0; in_operation = 0;
    fwd_ex_valid = 0; fwd_ex_rd = 0; fwd_ex_value = 0; fwd_ex_is_load = 0;
    fwd_wb_valid = 0; fwd_wb_rd = 0; fwd_wb_value = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [W-1:0] v1,
                       input logic [W-1:0] v2, input logic bsel, input logic [W-1:0] imm);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = 5'd9;
    in_rs1_value = v1; in_rs2_value = v2; in_b_sel_imm = bsel; in_imm = imm;
    in_a_sel_pc = 0; in_pc = 64'h1000; in_operation = 3'b000;
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clk); #1;

    // 1: reset for two cycles
    edge_step();
    mid();
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_in_ready",  W'(in_ready),  W'(1));
    edge_step();
    reset = 0;
    mid();
    check("rst_input_a",   input_a,        '0);
    check("rst_input_b",   input_b,        '0);
    check("rst_operation", W'(operation),  '0);
    check("rst_out_rd",    W'(out_rd),     '0);
    edge_step();

    // 2: pass-through with immediate
    issue(5'd1, 5'd2, 64'd5, 64'd0, 1'b1, 64'd7);
    mid(); edge_step();
    in_valid = 0;
    mid();
    check("pt_out_valid", W'(out_valid), W'(1));
    check("pt_input_a",   input_a,       64'd5);
    check("pt_input_b",   input_b,       64'd7);
    check("pt_operation", W'(operation), '0);
    edge_step();

    // 3: EX beats WB; x0 never forwarded
    issue(5'd3, 5'd2, 64'h1, 64'h2, 1'b0, 64'h0);
    mid(); edge_step();
    in_valid = 0;
    fwd_ex_valid = 1; fwd_ex_rd = 5'd3; fwd_ex_value = 64'h10;
    fwd_wb_valid = 1; fwd_wb_rd = 5'd3; fwd_wb_value = 64'h20;
    mid();
    check("fwd_prio_a", input_a, 64'h10);
    edge_step();
    idle();
    fwd_ex_valid = 1; fwd_ex_rd = 5'd0; fwd_ex_value = 64'hFF;
    issue(5'd0, 5'd2, 64'h55, 64'h2, 1'b0, 64'h0);
    mid(); edge_step();
    in_valid = 0;
    mid();
    check("fwd_x0_a", input_a, 64'h55);
    edge_step();
    idle();

    // 4: back-pressure with WB arriving mid-stall
    issue(5'd1, 5'd4, 64'h3, 64'h11, 1'b0, 64'h0);
    out_ready = 0;
    mid(); edge_step();
    in_valid = 0;
    for (int c = 0; c < 3; c++) begin
      fwd_wb_valid = (c == 1); fwd_wb_rd = 5'd4; fwd_wb_value = 64'h99;
      mid();
      check("bp_in_ready", W'(in_ready), '0);
      edge_step();
    end
    fwd_wb_valid = 0;
    out_ready = 1;
    mid();
    check("bp_out_valid", W'(out_valid), W'(1));
    check("bp_input_b",   input_b,       64'h99);
    edge_step();

    // 5: load-use stall resolved by WB
    issue(5'd6, 5'd2, 64'h1, 64'h2, 1'b0, 64'h0);
    mid(); edge_step();
    in_valid = 0;
    fwd_ex_valid = 1; fwd_ex_is_load = 1; fwd_ex_rd = 5'd6; fwd_ex_value = 64'hDEAD;
    mid();
    check("lu_out_valid", W'(out_valid), '0);
    check("lu_in_ready",  W'(in_ready),  '0);
    edge_step();
    fwd_ex_valid = 0; fwd_ex_is_load = 0;
    fwd_wb_valid = 1; fwd_wb_rd = 5'd6; fwd_wb_value = 64'hAB;
    mid();
    check("lu_release_valid", W'(out_valid), W'(1));
    check("lu_release_a",     input_a,       64'hAB);
    edge_step();
    idle();

    // 6: flush beats capture; reset while stalled
    issue(5'd1, 5'd2, 64'h1, 64'h2, 1'b0, 64'h0);
    out_ready = 0;
    mid(); edge_step();
    flush = 1;
    issue(5'd3, 5'd4, 64'h7, 64'h8, 1'b0, 64'h0);
    mid();
    check("fl_out_valid", W'(out_valid), '0);
    edge_step();
    flush = 0; in_valid = 0;
    mid();
    check("fl_after_valid", W'(out_valid), '0);
    check("fl_after_ready", W'(in_ready),  W'(1));
    edge_step();
    issue(5'd6, 5'd2, 64'h1, 64'h2, 1'b0, 64'h0);
    mid(); edge_step();
    in_valid = 0;
    fwd_ex_valid = 1; fwd_ex_is_load = 1; fwd_ex_rd = 5'd6;
    mid();
    check("rs_stall_ready", W'(in_ready), '0);
    reset = 1;
    edge_step();
    reset = 0;
    mid();
    check("rs_out_valid", W'(out_valid), '0);
    check("rs_in_ready",  W'(in_ready),  W'(1));
    check("rs_input_a",   input_a,       '0);
    check("rs_input_b",   input_b,       '0);
    edge_step();
    idle();

    // Randomized traffic with small register indices to force collisions.
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(63) == 0);
      flush          = ($urandom_range(15) == 0);
      in_valid       = ($urandom_range(9) < 7);
      out_ready      = ($urandom_range(9) < 7);
      in_rs1         = 5'($urandom_range(7));
      in_rs2         = 5'($urandom_range(7));
      in_rd          = 5'($urandom_range(31));
      in_rs1_value   = {$urandom, $urandom};
      in_rs2_value   = {$urandom, $urandom};
      in_imm         = {$urandom, $urandom};
      in_pc          = {$urandom, $urandom};
      in_a_sel_pc    = ($urandom_range(3) == 0);
      in_b_sel_imm   = ($urandom_range(1) == 0);
      in_operation   = 3'($urandom_range(7));
      fwd_ex_valid   = ($urandom_range(1) == 0);
      fwd_ex_is_load = ($urandom_range(3) == 0);
      fwd_ex_rd      = 5'($urandom_range(7));
      fwd_ex_value   = {$urandom, $urandom};
      fwd_wb_valid   = ($urandom_range(1) == 0);
      fwd_wb_rd      = 5'($urandom_range(7));
      fwd_wb_value   = {$urandom, $urandom};
      mid();
      edge_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
